// File: rtl/lfsr_prbs_pkg.sv
// Shared PRBS definitions: mode encodings, per-mode polynomial constants and seeds.
// Used by the generator today and intended for the matching PRBS checker.
package lfsr_prbs_pkg;

  localparam int STATE_W = 31;

  typedef enum logic [2:0] {
    MODE_PRBS7  = 3'd0,
    MODE_PRBS9  = 3'd1,
    MODE_PRBS15 = 3'd2,
    MODE_PRBS23 = 3'd3,
    MODE_PRBS31 = 3'd4
  } prbs_mode_e;

  typedef enum logic {
    ST_LOAD,
    ST_RUN
  } gen_state_e;

  // Bit indices (W-1, T-1) of the two feedback taps in the shift register.
  typedef struct packed {
    logic [4:0] msb;
    logic [4:0] tap;
  } prbs_poly_t;

  localparam prbs_mode_e       RESET_MODE = MODE_PRBS31;
  localparam logic [STATE_W-1:0] PRBS_SEED  = '1;

  function automatic logic mode_is_valid(input logic [2:0] m);
    return m <= 3'd4;
  endfunction

  function automatic prbs_poly_t prbs_poly(input prbs_mode_e m);
    case (m)
      MODE_PRBS7:  return '{msb: 5'd6,  tap: 5'd5};
      MODE_PRBS9:  return '{msb: 5'd8,  tap: 5'd4};
      MODE_PRBS15: return '{msb: 5'd14, tap: 5'd13};
      MODE_PRBS23: return '{msb: 5'd22, tap: 5'd17};
      default:     return '{msb: 5'd30, tap: 5'd27};
    endcase
  endfunction

  function automatic logic [STATE_W-1:0] prbs_mask(input prbs_mode_e m);
    case (m)
      MODE_PRBS7:  return 31'h0000_007F;
      MODE_PRBS9:  return 31'h0000_01FF;
      MODE_PRBS15: return 31'h0000_7FFF;
      MODE_PRBS23: return 31'h007F_FFFF;
      default:     return 31'h7FFF_FFFF;
    endcase
  endfunction

  function automatic logic [STATE_W-1:0] prbs_seed(input prbs_mode_e m);
    return PRBS_SEED & prbs_mask(m);
  endfunction

endpackage

// File: rtl/lfsr_prbs_gen_mode_if.sv
// Output word stream of the PRBS generator with a valid/ready handshake.
interface lfsr_prbs_gen_mode_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_out;
  logic                  out_valid;
  logic                  out_ready;

  modport master (output data_out, output out_valid, input out_ready);
  modport slave  (input data_out, input out_valid, output out_ready);
endinterface

// File: rtl/lfsr_prbs_mode_step.sv
// Combinational multi-step Fibonacci LFSR: advances the state DATA_WIDTH serial
// steps in the selected mode; raw_bits[i] is the i-th generated feedback bit.
module lfsr_prbs_mode_step
  import lfsr_prbs_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [STATE_W-1:0]    state,
  input  prbs_mode_e            mode,
  output logic [STATE_W-1:0]    next_state,
  output logic [DATA_WIDTH-1:0] raw_bits
);

  prbs_poly_t          poly;
  logic [STATE_W-1:0]  mask;
  logic [STATE_W-1:0]  s;
  logic                fb;

  always_comb begin
    // NOTE: every variable gets a value before any branch or loop so no latch
    // can be inferred; blocking '=' is used because each loop iteration must
    // see the state produced by the previous one.
    poly     = prbs_poly(mode);
    mask     = prbs_mask(mode);
    s        = state;
    fb       = 1'b0;
    raw_bits = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      fb          = s[poly.msb] ^ s[poly.tap];
      s           = {s[STATE_W-2:0], fb} & mask;
      raw_bits[i] = fb;
    end
    next_state = s;
  end

endmodule

// File: rtl/lfsr_prbs_gen_mode.sv
// Runtime-selectable PRBS7/9/15/23/31 word generator with pattern restart,
// single-bit error injection and a valid/ready output handshake.
module lfsr_prbs_gen_mode
  import lfsr_prbs_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int INVERT     = 1,
  parameter int REVERSE    = 0,
  parameter int ERR_BIT    = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [2:0]                  mode,
  input  logic                        mode_load,
  input  logic                        inject_err,
  output logic                        mode_err,
  output logic [2:0]                  cur_mode,
  lfsr_prbs_gen_mode_if.master        bus
);

  localparam logic                  INV_BIT  = (INVERT != 0);
  localparam logic [DATA_WIDTH-1:0] ERR_MASK = DATA_WIDTH'(1) << ERR_BIT;

  gen_state_e            fsm_q;
  prbs_mode_e            cur_mode_q;
  logic [STATE_W-1:0]    s_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  err_pend_q;
  logic                  mode_err_q;

  logic [STATE_W-1:0]    step_next;
  logic [DATA_WIDTH-1:0] raw_bits;
  logic [DATA_WIDTH-1:0] word;
  logic                  mode_ok;
  logic                  restart;
  logic                  load_word;
  logic                  apply_err;

  lfsr_prbs_mode_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_step (
    .state      (s_q),
    .mode       (cur_mode_q),
    .next_state (step_next),
    .raw_bits   (raw_bits)
  );

  // Output polarity and bit order: generation order i maps to the MSB end
  // unless REVERSE places the first generated bit at data_out[0].
  always_comb begin
    word = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (REVERSE != 0) word[i]                = raw_bits[i] ^ INV_BIT;
      else              word[DATA_WIDTH-1-i]   = raw_bits[i] ^ INV_BIT;
    end
  end

  assign mode_ok   = mode_is_valid(mode);
  assign restart   = mode_load && mode_ok;
  assign load_word = (fsm_q == ST_LOAD) || (valid_q && bus.out_ready);
  // A pulse arriving in the same cycle as a load is honoured by that load.
  assign apply_err = err_pend_q || inject_err;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values; the output data register is reset because its
    // reset value is architecturally visible on data_out.
    if (!rst_n) begin
      fsm_q      <= ST_LOAD;
      cur_mode_q <= RESET_MODE;
      s_q        <= PRBS_SEED;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_pend_q <= 1'b0;
      mode_err_q <= 1'b0;
    end else begin
      mode_err_q <= mode_load && !mode_ok;
      if (restart) begin
        // The word on the bus this cycle may still be taken by the consumer;
        // it belongs to the old pattern and is simply not replaced.
        cur_mode_q <= prbs_mode_e'(mode);
        s_q        <= prbs_seed(prbs_mode_e'(mode));
        fsm_q      <= ST_LOAD;
        valid_q    <= 1'b0;
        err_pend_q <= apply_err;
      end else if (load_word) begin
        data_q     <= apply_err ? (word ^ ERR_MASK) : word;
        s_q        <= step_next;
        fsm_q      <= ST_RUN;
        valid_q    <= 1'b1;
        err_pend_q <= 1'b0;
      end else begin
        err_pend_q <= apply_err;
      end
    end
  end

  assign bus.data_out  = data_q;
  assign bus.out_valid = valid_q;
  assign mode_err      = mode_err_q;
  assign cur_mode      = cur_mode_q;

endmodule

// File: tb/tb_lfsr_prbs_gen_mode.sv
// Directed bench for lfsr_prbs_gen_mode: two instances (MSB-first inverted and
// LSB-first true polarity) checked against hand values and a serial reference LFSR.
module tb_lfsr_prbs_gen_mode;

  logic       clk;
  logic       rst_n;
  logic [2:0] mode;
  logic       mode_load;
  logic       inject_err;
  logic       ready;
  logic       mode_err_a, mode_err_b;
  logic [2:0] cur_mode_a, cur_mode_b;

  int checks;
  int failures;

  lfsr_prbs_gen_mode_if #(.DATA_WIDTH(8)) bus_a ();
  lfsr_prbs_gen_mode_if #(.DATA_WIDTH(8)) bus_b ();
  assign bus_a.out_ready = ready;
  assign bus_b.out_ready = ready;

  lfsr_prbs_gen_mode #(
    .DATA_WIDTH(8), .INVERT(1), .REVERSE(0), .ERR_BIT(0)
  ) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .mode_load  (mode_load),
    .inject_err (inject_err),
    .mode_err   (mode_err_a),
    .cur_mode   (cur_mode_a),
    .bus        (bus_a)
  );

  lfsr_prbs_gen_mode #(
    .DATA_WIDTH(8), .INVERT(0), .REVERSE(1), .ERR_BIT(5)
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .mode_load  (mode_load),
    .inject_err (inject_err),
    .mode_err   (mode_err_b),
    .cur_mode   (cur_mode_b),
    .bus        (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-derived first words after seeding, per mode (instance a / instance b).
  logic [7:0] first_a [5] = '{8'hFD, 8'hF8, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] first_b [5] = '{8'h40, 8'hE0, 8'h00, 8'h00, 8'h00};
  int         w_tab   [5] = '{7, 9, 15, 23, 31};
  int         t_tab   [5] = '{6, 5, 14, 18, 28};

  // Reference serial LFSR; exp_raw[i] is the i-th bit of the word on the bus.
  logic [30:0] m_s;
  logic [30:0] m_mask;
  logic [4:0]  m_msb;
  logic [4:0]  m_tap;
  logic [7:0]  exp_raw;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reseed(input int m);
    m_mask = (31'h7FFF_FFFF) >> (31 - w_tab[m]);
    m_s    = m_mask;
    m_msb  = 5'(w_tab[m] - 1);
    m_tap  = 5'(t_tab[m] - 1);
  endtask

  task automatic model_word(output logic [7:0] raw);
    logic f;
    for (int i = 0; i < 8; i++) begin
      f      = m_s[m_msb] ^ m_s[m_tap];
      m_s    = {m_s[29:0], f} & m_mask;
      raw[i] = f;
    end
  endtask

  function automatic logic [7:0] exp_a(input logic [7:0] raw);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = ~raw[i];
    return r;
  endfunction

  task automatic check_word(input string tag);
    check({tag, "_a"}, bus_a.data_out, exp_a(exp_raw));
    check({tag, "_b"}, bus_b.data_out, exp_raw);
  endtask

  // Accept n words, comparing every cycle; stalled cycles must hold the word.
  task automatic run_stream(input int n_words, input bit rand_ready, input string tag);
    int accepted = 0;
    int cycles   = 0;
    while (accepted < n_words && cycles < n_words * 4 + 20) begin
      check({tag, "_valid"}, bus_a.out_valid, 1'b1);
      check_word(tag);
      ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      if (ready) begin
        model_word(exp_raw);
        accepted++;
      end
      cycles++;
    end
    if (accepted < n_words) check({tag, "_budget"}, 64'(accepted), 64'(n_words));
  endtask

  task automatic do_mode_load(input int m);
    mode      = 3'(m);
    mode_load = 1'b1;
    ready     = 1'b1;
    step();
    mode_load = 1'b0;
    check("ld_valid_low", bus_a.out_valid, 1'b0);
    check("ld_cur_mode", cur_mode_a, 64'(m));
    step();
    check("ld_valid_high", bus_b.out_valid, 1'b1);
    check("ld_first_a", bus_a.data_out, first_a[m]);
    check("ld_first_b", bus_b.data_out, first_b[m]);
    model_reseed(m);
    model_word(exp_raw);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    mode       = 3'd0;
    mode_load  = 1'b0;
    inject_err = 1'b0;
    ready      = 1'b0;
    repeat (3) step();

    // Reset state.
    check("rst_data_a", bus_a.data_out, 8'h00);
    check("rst_valid", bus_a.out_valid, 1'b0);
    check("rst_mode_err", mode_err_a, 1'b0);
    check("rst_cur_mode", cur_mode_b, 3'd4);

    // PRBS31 by default, valid after the single LOAD cycle.
    rst_n = 1'b1;
    ready = 1'b1;
    step();
    check("def_valid", bus_a.out_valid, 1'b1);
    check("def_first_a", bus_a.data_out, 8'hFF);
    check("def_first_b", bus_b.data_out, 8'h00);
    model_reseed(4);
    model_word(exp_raw);
    run_stream(200, 1'b0, "def31");

    // PRBS7: first word then a 127-bit period, i.e. word 127 equals word 0.
    do_mode_load(0);
    run_stream(127, 1'b0, "p7");
    check("p7_period", bus_a.data_out, 8'hFD);
    run_stream(4096 - 127, 1'b0, "p7");

    for (int m = 1; m < 5; m++) begin
      do_mode_load(m);
      run_stream(4096, 1'b0, "mode");
    end

    // Random backpressure on PRBS31.
    run_stream(300, 1'b1, "bp");

    // Two inject pulses during a stall: one flip on the next loaded word only.
    ready      = 1'b0;
    inject_err = 1'b1;
    step();
    inject_err = 1'b0;
    step();
    inject_err = 1'b1;
    step();
    inject_err = 1'b0;
    check_word("inj_hold");
    ready = 1'b1;
    step();
    model_word(exp_raw);
    check("inj_word_a", bus_a.data_out, exp_a(exp_raw) ^ 8'h01);
    check("inj_word_b", bus_b.data_out, exp_raw ^ 8'h20);
    step();
    model_word(exp_raw);
    run_stream(20, 1'b0, "inj_after");

    // Reserved mode rejected while stalled; stream and mode unchanged.
    ready     = 1'b0;
    check("rsv_err_before", mode_err_a, 1'b0);
    mode      = 3'd5;
    mode_load = 1'b1;
    step();
    mode_load = 1'b0;
    check("rsv_err_pulse", mode_err_a, 1'b1);
    check("rsv_cur_mode", cur_mode_a, 3'd4);
    check("rsv_valid", bus_a.out_valid, 1'b1);
    check_word("rsv_hold");
    step();
    check("rsv_err_clear", mode_err_b, 1'b0);
    run_stream(20, 1'b0, "rsv_after");

    // Restart to PRBS15 while a transfer is happening.
    do_mode_load(2);
    run_stream(50, 1'b1, "p15");

    // Asynchronous reset mid-stream, then PRBS31 restart.
    ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", bus_a.out_valid, 1'b0);
    check("arst_data_a", bus_a.data_out, 8'h00);
    check("arst_cur_mode", cur_mode_a, 3'd4);
    step();
    rst_n = 1'b1;
    step();
    check("rearm_first_a", bus_a.data_out, 8'hFF);
    check("rearm_valid", bus_a.out_valid, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_prbs_gen_mode.md
# lfsr_prbs_gen_mode

Runtime-selectable PRBS pattern generator, successor to the fixed-polynomial PRBS generator. It produces DATA_WIDTH bits per transfer of PRBS7/9/15/23/31 (ITU-T O.150 polynomials) selected by a mode input, with synchronous pattern restart, single-bit error injection and a valid/ready output handshake. It sits at the transmit side of link BER test logic, feeding serializers or loopback paths.

## Interface
- DATA_WIDTH, 8: bits per output word, 1..64.
- INVERT, 1: 1 = output bits inverted (O.150 convention for PRBS15/23/31 framing).
- REVERSE, 0: 0 = first generated bit in data_out[DATA_WIDTH-1] (MSB-first); 1 = first bit in data_out[0].
- ERR_BIT, 0: data_out bit index flipped by error injection.

- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  3  pattern select: 0 PRBS7, 1 PRBS9, 2 PRBS15, 3 PRBS23, 4 PRBS31; 5-7 reserved.
- mode_load  in  1  pulse: restart generator in the mode presented this cycle.
- inject_err  in  1  pulse: flip ERR_BIT of the next word loaded into the output register.
- data_out  out  DATA_WIDTH  current word.
- out_valid  out  1  data_out valid.
- out_ready  in  1  consumer accepts data_out when out_valid && out_ready.
- mode_err  out  1  one-cycle pulse: mode_load with reserved mode was rejected.
- cur_mode  out  3  mode in effect.

## Operation
- Single 31-bit Fibonacci state s; active width W and tap T per mode: PRBS7 (7,6), PRBS9 (9,5), PRBS15 (15,14), PRBS23 (23,18), PRBS31 (31,28). Bits above W unused, held 0.
- Serial step: f = s[W-1] ^ s[T-1]; s <= {s[W-2:0], f} (within W); generated bit = f ^ INVERT.
- One word = DATA_WIDTH consecutive serial steps, computed combinationally in one cycle; bit ordering per REVERSE.
- Seed: all ones in low W bits, on reset and on every accepted mode_load.
- FSM states: LOAD, RUN.
  - LOAD: out_valid = 0; compute first word from seed, register it, advance s; -> RUN.
  - RUN: out_valid = 1; on transfer (out_valid && out_ready) register next word, advance s; else hold data_out and s.
  - mode_load with valid mode in any state: latch cur_mode, reseed, -> LOAD next cycle. Word presented that cycle is still consumed if out_ready was high (it belongs to the old pattern).
  - mode_load with reserved mode: ignored, state/cur_mode/data unchanged, mode_err = 1 next cycle.
- Error injection: inject_err sets err_pend; the next word loaded into the output register (LOAD or RUN transfer) has ERR_BIT XORed and clears err_pend. inject_err coincident with a load applies to that load. Multiple pulses before a load collapse to one flip. err_pend survives mode_load; cleared only by use or reset.
- LFSR state is never corrupted by injection; subsequent words are error-free.

## Timing
- Reset values: data_out = 0, out_valid = 0, mode_err = 0, cur_mode = 4 (PRBS31), FSM = LOAD, s = all ones, err_pend = 0.
- First out_valid: first rising edge after rst_n deasserts + 1 cycle (LOAD lasts exactly one cycle).
- Throughput: one word per cycle while out_ready held high.
- mode_load at edge N: out_valid low after edge N+1, first new-mode word valid after edge N+2.
- out_valid never drops in RUN except via mode_load; data_out stable while out_valid && !out_ready.
- Reset assertion mid-stream: outputs return to reset values immediately (asynchronous).

## Structure
- Package lfsr_prbs_pkg: mode encodings, per-mode width/tap constants, seed constant; reused by the future PRBS checker.
- Sub-module lfsr_prbs_mode_step: combinational; inputs state and mode, outputs next state and DATA_WIDTH raw bits (before INVERT/REVERSE/injection). Top holds FSM, registers, handshake, injection.

## Test plan
- Reset, mode_load PRBS7 with INVERT=0, out_ready=1, DATA_WIDTH=8 -> first word 0x02; with INVERT=1 -> 0xFD; sequence repeats every 127 bits versus software model.
- Each mode 0-4, out_ready=1, 4096 words -> bit stream matches reference model; PRBS31 default after reset without mode_load.
- Random out_ready backpressure -> data_out/out_valid held while stalled; accepted stream identical to stall-free stream.
- inject_err pulsed twice before one transfer -> exactly one word differs from model, only at ERR_BIT; following words match.
- mode_load=5 -> mode_err pulse one cycle later, cur_mode and stream unchanged; mode_load=2 during transfer -> stalled word consumed, out_valid low one cycle, then PRBS15 from seed.
- rst_n asserted mid-stream with out_ready=1 -> outputs at reset values same cycle; restart yields PRBS31 first word.
